// File: rtl/rr_sel_arbiter4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
//   ena        : global enable; when low the arbiter freezes
//   req        : per-requester request vector (bit i requests mux input i)
//   grant      : registered one-hot grant
//   sel        : registered 2-bit mux select (current or most recent grantee)
//   valid      : registered, high while a grant is active
//   hold_count : registered, cycles the current grant has been held minus 1
// master = requester side, slave = arbiter side.
interface rr_sel_arbiter4_if #(
    parameter int unsigned CW = 4
);
    logic          ena;
    logic [3:0]    req;
    logic [3:0]    grant;
    logic [1:0]    sel;
    logic          valid;
    logic [CW-1:0] hold_count;

    modport master (
        output ena,
        output req,
        input  grant,
        input  sel,
        input  valid,
        input  hold_count
    );

    modport slave (
        input  ena,
        input  req,
        output grant,
        output sel,
        output valid,
        output hold_count
    );
endinterface

// File: rtl/rr_sel_arbiter4.sv
// Four-requester round-robin arbiter driving the select of a 4:1 word mux.
// A hold counter forces rotation after HOLD_MAX consecutive cycles when other
// requesters are waiting; an owner that drops its request is replaced on the
// same edge with no idle bubble.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rr_sel_arbiter4_if slave modport (ena, req in; grant, sel, valid,
//         hold_count out, all registered)
module rr_sel_arbiter4 #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CW       = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_sel_arbiter4_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    sel_q, sel_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [1:0]    last_q, last_d;

    logic [1:0]    win;
    logic          any_req;
    logic          expired;

    assign any_req = |bus.req;
    assign expired = (hold_q == CW'(HOLD_MAX - 1));

    // Search last+1, last+2, last+3, last; scanning backwards lets the
    // nearest set request overwrite farther ones.
    always_comb begin
        logic [1:0] cand;
        win  = last_q;
        cand = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (bus.req[cand]) begin
                win = cand;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        last_d  = last_q;

        if (bus.ena) begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_d = GRANT;
                        grant_d = 4'b0001 << win;
                        sel_d   = win;
                        valid_d = 1'b1;
                        hold_d  = '0;
                        last_d  = win;
                    end
                end
                GRANT: begin
                    if (!bus.req[sel_q]) begin
                        // Release wins over expiry; other pending requests
                        // take over on this same edge.
                        if (any_req) begin
                            grant_d = 4'b0001 << win;
                            sel_d   = win;
                            last_d  = win;
                            hold_d  = '0;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                            valid_d = 1'b0;
                            hold_d  = '0;
                        end
                    end else if (expired) begin
                        // Owner ranks last in the search, so it is re-granted
                        // only when it is the sole requester.
                        grant_d = 4'b0001 << win;
                        sel_d   = win;
                        last_d  = win;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.sel        = sel_q;
    assign bus.valid      = valid_q;
    assign bus.hold_count = hold_q;

endmodule

// File: doc/rr_sel_arbiter4.md
# rr_sel_arbiter4

Four-requester round-robin arbiter that generates the 2-bit select for the datapath's 4:1 word mux and a matching one-hot grant. Each requester owns one mux input (requester i on input i). Grants are registered, so the mux select is glitch-free and stable for a whole cycle. A hold counter bounds how long any one requester keeps the mux before rotation is forced.

## Interface
- HOLD_MAX, 8: maximum consecutive cycles one requester may hold the grant while others wait; legal range 1..2^CW.
- CW, 4: width of the hold counter.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset. One clock; reset asserts asynchronously and is active-high.
- ena  input  1  when low, every register holds its value and outputs do not change.
- req  input  4  request vector; bit i requests mux input i.
- grant  output  4  one-hot grant, registered; all zeros when idle.
- sel  output  2  encoded index of the current or most recent grantee; drives the 4:1 mux select (0 selects in0 … 3 selects in3).
- valid  output  1  high while a grant is active; equals |grant.
- hold_count  output  CW  number of cycles the current grant has been held, minus 1.

## Operation
- State machine:
  - IDLE: no grant.
  - GRANT: owner = sel, grant = 1<<sel.
- Internal pointer `last` records the most recent grantee. Reset value is 3, so the first search starts at 0.
- Search order for a new grant is last+1, last+2, last+3, last (mod 4). The first set req bit in that order wins.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise go to GRANT with the search winner, hold_count=0, last=winner.
- GRANT, each enabled edge, checked in this priority:
  - **Owner releases** (req[owner]==0): if other requests are pending, grant the search winner directly with no idle cycle and set hold_count=0. If none are pending, go to IDLE.
  - **Expiry** (req[owner]==1 and hold_count==HOLD_MAX-1): force rotation by granting the search winner. The owner ranks last in the search order, so the owner is re-granted only if it is the sole requester. hold_count resets to 0 in either case.
  - **Otherwise:** keep the grant and increment hold_count.
- Simultaneous owner release and expiry are treated as release.
- Requests arriving in the same cycle as a release are eligible immediately.
- In IDLE, sel keeps the last grantee's index, so the mux output stays stable. grant=0, valid=0, hold_count=0.
- HOLD_MAX=1: with multiple requesters active, the grant rotates every cycle.
- ena low:
  - No state, pointer, or counter update.
  - req changes are ignored until ena returns high, then evaluated on the next edge.
- Invariants:
  - grant is always one-hot or zero.
  - valid == |grant.
  - When valid, grant == 1<<sel.

## Timing
- All outputs are registered with no combinational path from req to outputs.
- Reset values: grant=0, sel=0, valid=0, hold_count=0, last=3, state IDLE.
- Reset asserted mid-grant clears outputs immediately, without waiting for a clock. The first grant after reset deasserts follows the 1-cycle rule.
- Latency: req sampled at edge k produces grant/sel/valid after edge k. A grant is therefore visible the cycle after req is first seen high.
- A handover between owners takes exactly one edge, with no bubble.
- Worst-case wait for a continuous requester is 3·HOLD_MAX cycles after its req is first seen.

## Test plan
- **Reset/idle:** rst pulse, then req=0 for 5 cycles -> grant=0, sel=0, valid=0, hold_count=0 throughout. Asserting rst mid-grant clears grant with no clock edge.
- **Single request:** req=4'b0100 held for 3 edges -> grant=0100, sel=2, valid=1 after the first edge. hold_count shows 0,1,2. Dropping req gives grant=0, valid=0, sel stays 2.
- **Round-robin fairness, HOLD_MAX=1:** req=4'b1111 constant -> sel sequence 0,1,2,3,0,1 on consecutive cycles.
- **Expiry, HOLD_MAX=8:** req=4'b0011 held -> sel=0 for 8 cycles (hold_count 0..7), then sel=1 for 8 cycles, then back to 0.
- **Sole requester expiry:** req=4'b1000 held 20 cycles -> grant stays 1000 continuously. hold_count wraps 7->0 with no gap in valid.
- **Release handover and ena freeze:**
  - Owner 1 drops req while req[3] is set -> next cycle sel=3 with no idle cycle.
  - With ena=0 for 4 cycles during a grant, all outputs hold even if req changes. They resume updating on the first edge after ena=1.
